// File: rtl/uart_pkg.sv
// Shared UART definitions: bus register addresses, oversample ratio and
// baud-generator state encoding.
package uart_pkg;

   localparam logic [1:0] ADDR_DB_LOW  = 2'b10;
   localparam logic [1:0] ADDR_DB_HIGH = 2'b11;
   localparam int         OVERSAMPLE   = 16;
   localparam logic [3:0] OS_LAST      = 4'(OVERSAMPLE - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } brg_state_e;

   // A bus cycle is a write to this block only when selected and not a read.
   function automatic logic bus_write(input logic cs, input logic rw);
      return cs & ~rw;
   endfunction

endpackage

// File: rtl/baud_gen.sv
// Programmable baud-rate generator: a 16-bit divisor yields a 16x-baud receive
// strobe and a 1x-baud transmit strobe, both registered single-cycle pulses.
module baud_gen
   import uart_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       iocs,
   input  logic       iorw,
   input  logic [1:0] ioaddr,
   input  logic [7:0] databus_in,
   output logic       brg_rx_en,
   output logic       brg_tx_en,
   output logic       div_valid
);

   brg_state_e  r_state;
   brg_state_e  w_state_nxt;
   logic [7:0]  r_staging;
   logic [15:0] r_divisor;
   logic [15:0] r_cnt;
   logic [3:0]  r_os;
   logic        r_rx_en;
   logic        r_tx_en;
   logic        r_div_valid;

   logic        w_wr_low;
   logic        w_commit;
   logic [15:0] w_new_div;

   assign w_wr_low  = bus_write(iocs, iorw) & (ioaddr == ADDR_DB_LOW);
   assign w_commit  = bus_write(iocs, iorw) & (ioaddr == ADDR_DB_HIGH);
   assign w_new_div = {databus_in, r_staging};

   // Next-state logic: only a divisor commit moves the FSM.
   always_comb begin
      w_state_nxt = r_state;
      if (w_commit) begin
         if (w_new_div != 16'd0) begin
            w_state_nxt = ST_RUN;
         end else begin
            w_state_nxt = ST_IDLE;
         end
      end else begin
         w_state_nxt = r_state;
      end
   end

   // State register and its registered valid flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_div_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_div_valid <= (w_state_nxt == ST_RUN);
      end
   end

   // Low-byte staging register; the active divisor is untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_staging <= 8'd0;
      end else if (w_wr_low) begin
         r_staging <= databus_in;
      end else begin
         r_staging <= r_staging;
      end
   end

   // Divisor commit, period down-counter, oversample counter and strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_divisor <= 16'd0;
         r_cnt     <= 16'd0;
         r_os      <= 4'd0;
         r_rx_en   <= 1'b0;
         r_tx_en   <= 1'b0;
      end else if (w_commit) begin
         // A commit restarts the period; a zero divisor parks the counter at 0.
         r_divisor <= w_new_div;
         r_cnt     <= (w_new_div == 16'd0) ? 16'd0 : (w_new_div - 16'd1);
         r_os      <= 4'd0;
         r_rx_en   <= 1'b0;
         r_tx_en   <= 1'b0;
      end else if (r_state == ST_RUN) begin
         if (r_cnt == 16'd0) begin
            r_cnt   <= r_divisor - 16'd1;
            r_rx_en <= 1'b1;
            if (r_os == OS_LAST) begin
               r_os    <= 4'd0;
               r_tx_en <= 1'b1;
            end else begin
               r_os    <= r_os + 4'd1;
               r_tx_en <= 1'b0;
            end
         end else begin
            r_cnt   <= r_cnt - 16'd1;
            r_rx_en <= 1'b0;
            r_tx_en <= 1'b0;
         end
      end else begin
         r_rx_en <= 1'b0;
         r_tx_en <= 1'b0;
      end
   end

   assign brg_rx_en = r_rx_en;
   assign brg_tx_en = r_tx_en;
   assign div_valid = r_div_valid;

endmodule

// File: tb/tb_baud_gen.sv
// Self-checking bench for baud_gen: a cycle-count model predicts every output
// from the time elapsed since the last divisor commit.
module tb_baud_gen;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   logic [7:0] databus_in;
   logic       brg_rx_en;
   logic       brg_tx_en;
   logic       div_valid;

   int total = 0;
   int bad   = 0;
   int m_div   = 0;
   int m_stage = 0;
   int m_k     = 0;
   int n_rx    = 0;
   int n_tx    = 0;

   baud_gen dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .iocs       (iocs),
      .iorw       (iorw),
      .ioaddr     (ioaddr),
      .databus_in (databus_in),
      .brg_rx_en  (brg_rx_en),
      .brg_tx_en  (brg_tx_en),
      .div_valid  (div_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0d expected %0d (div=%0d k=%0d)",
                  nm, $time, act, exp, m_div, m_k);
      end
   endtask

   task automatic compare();
      int e_rx;
      int e_tx;
      e_rx = (m_div != 0 && m_k > 0 && (m_k % m_div) == 0) ? 1 : 0;
      e_tx = (m_div != 0 && m_k > 0 && (m_k % (16 * m_div)) == 0) ? 1 : 0;
      chk("brg_rx_en", int'(brg_rx_en), e_rx);
      chk("brg_tx_en", int'(brg_tx_en), e_tx);
      chk("div_valid", int'(div_valid), (m_div != 0) ? 1 : 0);
   endtask

   task automatic model_clear();
      m_div   = 0;
      m_stage = 0;
      m_k     = 0;
   endtask

   // One clock: update the model from the bus as sampled at the edge, then check.
   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         model_clear();
      end else begin
         m_k++;
         if (iocs && !iorw && ioaddr == 2'b10) begin
            m_stage = int'(databus_in);
         end else if (iocs && !iorw && ioaddr == 2'b11) begin
            m_div = int'(databus_in) * 256 + m_stage;
            m_k   = 0;
         end
      end
      #1;
      compare();
      n_rx += int'(brg_rx_en);
      n_tx += int'(brg_tx_en);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic bus(input logic cs, input logic rw, input logic [1:0] a, input logic [7:0] d);
      iocs       = cs;
      iorw       = rw;
      ioaddr     = a;
      databus_in = d;
      tick();
      iocs       = 1'b0;
      iorw       = 1'b1;
      ioaddr     = 2'b00;
      databus_in = 8'h00;
   endtask

   task automatic set_div(input logic [15:0] d);
      bus(1'b1, 1'b0, 2'b10, d[7:0]);
      bus(1'b1, 1'b0, 2'b11, d[15:8]);
   endtask

   initial begin
      int found;
      rst_n = 1'b0; iocs = 1'b0; iorw = 1'b1; ioaddr = 2'b00; databus_in = 8'h00;
      #1;
      compare();
      ticks(2);
      rst_n = 1'b1;

      // Idle after reset: nothing may pulse.
      n_rx = 0; n_tx = 0;
      ticks(1000);
      chk("idle_rx_count", n_rx, 0);
      chk("idle_tx_count", n_tx, 0);

      // Divisor 2: rx every 2 cycles, tx every 32.
      set_div(16'h0002);
      n_rx = 0; n_tx = 0;
      ticks(64);
      chk("div2_rx_count", n_rx, 32);
      chk("div2_tx_count", n_tx, 2);
      chk("div2_valid", int'(div_valid), 1);

      // Ignored bus cycles with data 8'h05 must not disturb the period.
      bus(1'b1, 1'b1, 2'b11, 8'h05);
      bus(1'b0, 1'b0, 2'b11, 8'h05);
      bus(1'b1, 1'b0, 2'b00, 8'h05);
      bus(1'b1, 1'b1, 2'b10, 8'h05);
      bus(1'b0, 1'b0, 2'b10, 8'h05);
      ticks(40);

      // Divisor 4, then recommit 3 mid-period.
      set_div(16'h0004);
      ticks(5);
      set_div(16'h0003);
      found = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (brg_rx_en && found == 0) found = i;
      end
      chk("first_rx_after_div3", found, 3);
      n_tx = 0;
      ticks(60);
      chk("div3_tx_count", n_tx, 1);

      // Committing zero stops everything.
      set_div(16'h0000);
      n_rx = 0;
      ticks(50);
      chk("zero_rx_count", n_rx, 0);
      chk("zero_valid", int'(div_valid), 0);

      // Reset mid-period at divisor 2.
      set_div(16'h0002);
      ticks(7);
      rst_n = 1'b0;
      #1;
      model_clear();
      compare();
      tick();
      rst_n = 1'b1;
      n_rx = 0;
      ticks(20);
      chk("post_reset_rx_count", n_rx, 0);

      // Divisor 1: rx constant, tx one in sixteen.
      set_div(16'h0001);
      n_rx = 0; n_tx = 0;
      ticks(32);
      chk("div1_rx_count", n_rx, 32);
      chk("div1_tx_count", n_tx, 2);

      // Maximum divisor: no early pulse.
      set_div(16'hFFFF);
      n_rx = 0;
      ticks(300);
      chk("ffff_rx_count", n_rx, 0);

      // Randomized bus traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            logic [7:0] d;
            logic [1:0] a;
            a = 2'($urandom_range(0, 3));
            d = 8'($urandom_range(0, 24));
            if (a == 2'b11 && $urandom_range(0, 9) != 0) d = 8'h00;
            bus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0), a, d);
         end else begin
            tick();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/baud_gen.md
BAUD_GEN -- requirements
Module: baud_gen

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have port iocs, input, 1: I/O chip select; a bus cycle is ignored unless high.
REQ-004 SHALL have port iorw, input, 1: 1 = read, 0 = write; only writes affect this block.
REQ-005 SHALL have port ioaddr, input, 2: register select; 2'b10 = DB_LOW, 2'b11 = DB_HIGH, others ignored.
REQ-006 SHALL have port databus_in, input, 8: write data, sampled on the write edge.
REQ-007 SHALL have port brg_rx_en, output, 1: one-cycle pulse at 16x baud, for the receiver.
REQ-008 SHALL have port brg_tx_en, output, 1: one-cycle pulse at 1x baud, feeding transmit's brg_tx_en.
REQ-009 SHALL have port div_valid, output, 1: high while a nonzero divisor is active.

Function
REQ-010 SHALL accept a write when iocs=1, iorw=0, ioaddr in {2'b10, 2'b11}, on a rising clk edge.
REQ-011 SHALL store a DB_LOW write in an 8-bit staging register; active divisor unchanged.
REQ-012 SHALL, on a DB_HIGH write, commit divisor = {databus_in, staging} (16 bits) in that same edge.
REQ-013 SHALL implement two states: IDLE (divisor == 0, no pulses) and RUN (divisor != 0).
REQ-014 SHALL go IDLE->RUN on commit of a nonzero divisor, and RUN->IDLE on commit of zero.
REQ-015 SHALL, on every commit, reload the 16-bit down-counter to divisor-1 and clear the 4-bit oversample counter.
REQ-016 SHALL, in RUN, decrement the down-counter each cycle; at 0, assert brg_rx_en for one cycle and reload divisor-1.
REQ-017 SHALL give a brg_rx_en period of exactly divisor cycles; divisor = 1 gives brg_rx_en high every cycle.
REQ-018 SHALL assert the first brg_rx_en exactly divisor cycles after the commit edge.
REQ-019 SHALL increment the oversample counter on each brg_rx_en, wrapping 15->0.
REQ-020 SHALL assert brg_tx_en in the same cycle as the brg_rx_en that wraps the counter 15->0 (every 16th pulse, period 16*divisor cycles).
REQ-021 SHALL register both outputs (no combinational path from bus inputs to outputs).
REQ-022 SHALL handle divisor 16'hFFFF without overflow: down-counter arithmetic is 16-bit unsigned, with no wrap below 0.
REQ-023 SHALL let a DB_LOW write in the same cycle as a counter reload not disturb the running period.
REQ-024 SHALL hold brg_rx_en = brg_tx_en = 0 in IDLE; div_valid = (state == RUN).

Reset
REQ-025 SHALL on rst_n=0 immediately clear staging, divisor, down-counter, oversample counter; state = IDLE.
REQ-026 SHALL drive brg_rx_en=0, brg_tx_en=0, div_valid=0 during and after reset until a nonzero commit.
REQ-027 SHALL treat reset mid-period as a full abort; no residual pulse after rst_n rises.

Structure
REQ-028 SHALL take ADDR_DB_LOW, ADDR_DB_HIGH, OVERSAMPLE=16 and the state enum from shared package uart_pkg.
REQ-029 SHALL be a single module with no sub-modules; est. 120-180 lines RTL.

Verification
REQ-030 SHALL test: write LOW=8'h02 then HIGH=8'h00 -> brg_rx_en every 2 cycles, brg_tx_en every 32 cycles, div_valid=1.
REQ-031 SHALL test: no writes after reset -> outputs 0 for 1000 cycles; commit 16'h0000 from RUN -> pulses stop, div_valid=0.
REQ-032 SHALL test: iorw=1 or iocs=0 or ioaddr=2'b00 with data 8'h05 -> divisor unchanged, no pulse-timing change.
REQ-033 SHALL test: divisor 4 running, commit 16'h0003 mid-period -> next brg_rx_en 3 cycles after commit, oversample count restarts.
REQ-034 SHALL test: rst_n low for 1 cycle mid-period at divisor 2 -> outputs 0 at once, stay 0 until recommit.
REQ-035 SHALL test: divisor 16'h0001 -> brg_rx_en constant 1, brg_tx_en high 1 cycle in every 16.
